// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX cartridge slot bus initiator.
//
// Contents:
//   bus_state_t : bus cycle state (IDLE, T1, T2, TW, T3, ABORT, RESP)
//   BUS_FLOAT   : value returned when nothing drives the data bus
//   bus_req_t   : request captured at accept {wr, io, addr, data}
//   sat_inc8    : saturating 8-bit increment used by the wait-tick counter
package msx_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        TW    = 3'd3,
        T3    = 3'd4,
        ABORT = 3'd5,
        RESP  = 3'd6
    } bus_state_t;

    localparam logic [7:0] BUS_FLOAT = 8'hFF;

    typedef struct packed {
        logic        wr;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_req_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msx_bus_initiator.sv
// Host-side initiator for the MSX cartridge slot bus.
//
// Turns one read/write request at a time into a Z80-timed memory or I/O
// cycle toward a cartridge, honours WAIT_n, samples read data qualified by
// BUS_BUSDIR_n and returns exactly one response per accepted request.
//
// Parameters:
//   WAIT_TIMEOUT : TW ticks after which the cycle is aborted (1..255)
//   EXTRA_WAIT   : forced wait ticks inserted after T2 on every cycle (0..3)
//
// Ports:
//   CLK, RESET            system clock, synchronous active-high reset
//   CLK_EN                bus tick, one CLK pulse per Z80 T-state
//   REQ_VALID/REQ_READY   request handshake (READY high only in IDLE)
//   REQ_WR/REQ_IO         1 = write / 1 = I/O cycle
//   REQ_ADDR/REQ_DATA     cycle address / write data
//   RSP_VALID             one-CLK pulse when the cycle finishes
//   RSP_DATA/RSP_TIMEOUT  read data (FF for write/float/abort), abort flag
//   BUS_ADDR/BUS_DOUT     slot address / data toward the cartridge
//   BUS_DIN/BUS_BUSDIR_n  data from cartridge, low = cartridge drives it
//   SLTSL_n MERQ_n IORQ_n RD_n WR_n   active-low bus strobes
//   WAIT_n                cartridge wait request, active-low
//
// State | meaning
//   IDLE  | ready for a request, strobes high
//   T1    | address stable, strobes high
//   T2    | select and RD_n/WR_n asserted, WAIT_n sampled
//   TW    | wait ticks: forced waits first, then WAIT_n, bounded by timeout
//   T3    | last strobed tick, read data captured on its closing tick
//   ABORT | like T3, but reports a timeout with floating data
//   RESP  | RSP_VALID high for one CLK
module msx_bus_initiator
    import msx_bus_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned EXTRA_WAIT   = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN,

    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WR,
    input  logic        REQ_IO,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_DATA,

    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_TIMEOUT,

    output logic [15:0] BUS_ADDR,
    output logic [7:0]  BUS_DOUT,
    input  logic [7:0]  BUS_DIN,
    input  logic        BUS_BUSDIR_n,
    output logic        SLTSL_n,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    input  logic        WAIT_n
);

    localparam logic [7:0] TIMEOUT_W8 = 8'(WAIT_TIMEOUT);
    localparam logic [7:0] EXTRA_W8   = 8'(EXTRA_WAIT);

    bus_state_t state, state_nx;
    bus_req_t   req, req_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic [7:0] wait_cnt_inc;
    logic       forced_done;
    logic       timeout_hit;

    logic       sltsl_nx, merq_nx, iorq_nx, rd_nx, wr_nx;
    logic       rsp_valid_nx, rsp_timeout_nx;
    logic [7:0] rsp_data_nx;

    // The captured request drives the bus directly, so address and write
    // data change on the accept edge and stay stable for the whole cycle.
    assign BUS_ADDR  = req.addr;
    assign BUS_DOUT  = req.data;
    assign REQ_READY = (state == IDLE);

    // Counter value including the tick being taken now; this lets the
    // forced-wait and timeout decisions use the count after this tick.
    assign wait_cnt_inc = sat_inc8(wait_cnt);
    assign forced_done  = (wait_cnt_inc >= EXTRA_W8);
    assign timeout_hit  = (wait_cnt_inc == TIMEOUT_W8);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            req         <= '0;
            wait_cnt    <= '0;
            SLTSL_n     <= 1'b1;
            MERQ_n      <= 1'b1;
            IORQ_n      <= 1'b1;
            RD_n        <= 1'b1;
            WR_n        <= 1'b1;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= BUS_FLOAT;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            state       <= state_nx;
            req         <= req_nx;
            wait_cnt    <= wait_cnt_nx;
            SLTSL_n     <= sltsl_nx;
            MERQ_n      <= merq_nx;
            IORQ_n      <= iorq_nx;
            RD_n        <= rd_nx;
            WR_n        <= wr_nx;
            RSP_VALID   <= rsp_valid_nx;
            RSP_DATA    <= rsp_data_nx;
            RSP_TIMEOUT <= rsp_timeout_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        req_nx         = req;
        wait_cnt_nx    = wait_cnt;
        sltsl_nx       = SLTSL_n;
        merq_nx        = MERQ_n;
        iorq_nx        = IORQ_n;
        rd_nx          = RD_n;
        wr_nx          = WR_n;
        rsp_valid_nx   = 1'b0;
        rsp_data_nx    = RSP_DATA;
        rsp_timeout_nx = RSP_TIMEOUT;

        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    req_nx.wr   = REQ_WR;
                    req_nx.io   = REQ_IO;
                    req_nx.addr = REQ_ADDR;
                    req_nx.data = REQ_DATA;
                    wait_cnt_nx = '0;
                    state_nx    = T1;
                end
            end

            T1: begin
                if (CLK_EN) begin
                    // Slot select only accompanies memory cycles; IORQ_n
                    // only I/O cycles. Exactly one of RD_n/WR_n goes low.
                    sltsl_nx = req.io;
                    merq_nx  = req.io;
                    iorq_nx  = ~req.io;
                    rd_nx    = req.wr;
                    wr_nx    = ~req.wr;
                    state_nx = T2;
                end
            end

            T2: begin
                if (CLK_EN) begin
                    if ((EXTRA_W8 != 8'd0) || !WAIT_n) begin
                        state_nx = TW;
                    end else begin
                        state_nx = T3;
                    end
                end
            end

            TW: begin
                if (CLK_EN) begin
                    wait_cnt_nx = wait_cnt_inc;
                    // A cycle that becomes releasable on the timeout tick
                    // completes normally rather than aborting.
                    if (forced_done && WAIT_n) begin
                        state_nx = T3;
                    end else if (timeout_hit) begin
                        state_nx = ABORT;
                    end
                end
            end

            T3: begin
                if (CLK_EN) begin
                    sltsl_nx       = 1'b1;
                    merq_nx        = 1'b1;
                    iorq_nx        = 1'b1;
                    rd_nx          = 1'b1;
                    wr_nx          = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    rsp_timeout_nx = 1'b0;
                    rsp_data_nx    = (!req.wr && !BUS_BUSDIR_n) ? BUS_DIN : BUS_FLOAT;
                    state_nx       = RESP;
                end
            end

            ABORT: begin
                if (CLK_EN) begin
                    sltsl_nx       = 1'b1;
                    merq_nx        = 1'b1;
                    iorq_nx        = 1'b1;
                    rd_nx          = 1'b1;
                    wr_nx          = 1'b1;
                    rsp_valid_nx   = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    rsp_data_nx    = BUS_FLOAT;
                    state_nx       = RESP;
                end
            end

            RESP: begin
                state_nx = IDLE;
            end

            default: begin
                sltsl_nx = 1'b1;
                merq_nx  = 1'b1;
                iorq_nx  = 1'b1;
                rd_nx    = 1'b1;
                wr_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Self-checking bench for msx_bus_initiator. Two instances share the
// stimulus: one without forced waits (timeout 16), one with EXTRA_WAIT=2
// (timeout 20). Each transaction is predicted from the bus timing rules.
module tb_msx_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLK_EN;
    logic        WAIT_n;
    logic        BUS_BUSDIR_n;
    logic        REQ_WR;
    logic        REQ_IO;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_DATA;
    logic [7:0]  BUS_DIN;

    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_timeout;
    logic [1:0]  sltsl, merq, iorq, rd, wr;
    logic [7:0]  rsp_data [2];
    logic [15:0] bus_addr [2];
    logic [7:0]  bus_dout [2];

    int n_pass  = 0;
    int n_total = 0;

    // wlo[i] = 1 means WAIT_n is low on the i-th bus tick after accept.
    bit wlo [64];

    always #5 CLK = ~CLK;

    msx_bus_initiator #(.WAIT_TIMEOUT(16), .EXTRA_WAIT(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN),
        .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_WR(REQ_WR), .REQ_IO(REQ_IO), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .RSP_VALID(rsp_valid[0]), .RSP_DATA(rsp_data[0]), .RSP_TIMEOUT(rsp_timeout[0]),
        .BUS_ADDR(bus_addr[0]), .BUS_DOUT(bus_dout[0]), .BUS_DIN(BUS_DIN),
        .BUS_BUSDIR_n(BUS_BUSDIR_n), .SLTSL_n(sltsl[0]), .MERQ_n(merq[0]),
        .IORQ_n(iorq[0]), .RD_n(rd[0]), .WR_n(wr[0]), .WAIT_n(WAIT_n)
    );

    msx_bus_initiator #(.WAIT_TIMEOUT(20), .EXTRA_WAIT(2)) dut1 (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN),
        .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_WR(REQ_WR), .REQ_IO(REQ_IO), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .RSP_VALID(rsp_valid[1]), .RSP_DATA(rsp_data[1]), .RSP_TIMEOUT(rsp_timeout[1]),
        .BUS_ADDR(bus_addr[1]), .BUS_DOUT(bus_dout[1]), .BUS_DIN(BUS_DIN),
        .BUS_BUSDIR_n(BUS_BUSDIR_n), .SLTSL_n(sltsl[1]), .MERQ_n(merq[1]),
        .IORQ_n(iorq[1]), .RD_n(rd[1]), .WR_n(wr[1]), .WAIT_n(WAIT_n)
    );

    // Reference: number of TW ticks and whether the cycle times out.
    // TW tick j is bus tick 2+j; release needs j >= forced waits and WAIT_n
    // high on that tick; reaching the timeout count without release aborts.
    function automatic void model(input int k, output int tw, output bit to);
        int e;
        int t;
        e  = (k == 1) ? 2 : 0;
        t  = (k == 1) ? 20 : 16;
        tw = 0;
        to = 1'b0;
        if (e > 0 || wlo[2]) begin
            for (int j = 1; j <= t; j++) begin
                if (j >= e && !wlo[2 + j]) begin
                    tw = j;
                    return;
                end
            end
            tw = t;
            to = 1'b1;
        end
    endfunction

    task automatic run_txn(input bit w, input bit io, input logic [15:0] addr,
                           input logic [7:0] data, input logic [7:0] din,
                           input bit busdir_n, input bit hold);
        int tick, cyc, post;
        int lat [2];
        int rcnt [2];
        int busy_rdy [2];
        int addr_bad [2];
        int both_low [2];
        int lo_s [2], lo_m [2], lo_i [2], lo_r [2], lo_w [2];
        bit done [2];
        logic [7:0] got_d [2];
        logic got_to [2];
        int tw, s;
        bit to;
        logic [7:0] exp_d;

        for (int k = 0; k < 2; k++) begin
            lat[k] = -1; rcnt[k] = 0; busy_rdy[k] = 0; addr_bad[k] = 0; both_low[k] = 0;
            lo_s[k] = 0; lo_m[k] = 0; lo_i[k] = 0; lo_r[k] = 0; lo_w[k] = 0;
            done[k] = 1'b0; got_d[k] = 8'h00; got_to[k] = 1'b0;
        end

        @(negedge CLK);
        REQ_WR = w; REQ_IO = io; REQ_ADDR = addr; REQ_DATA = data;
        BUS_DIN = din; BUS_BUSDIR_n = busdir_n;
        req_valid = 2'b11;
        CLK_EN = 1'($urandom_range(0, 1));
        WAIT_n = 1'($urandom_range(0, 1));
        for (int k = 0; k < 2; k++) begin
            if (req_ready[k] !== 1'b1) $display("FAIL ready_before_accept dut%0d: got %b want 1", k, req_ready[k]);
            else n_pass++;
            n_total++;
        end

        @(negedge CLK);
        if (hold) begin
            REQ_ADDR = ~addr; REQ_DATA = ~data; REQ_WR = ~w;
        end else begin
            req_valid = 2'b00;
        end

        tick = 0; cyc = 0; post = 0;
        while (cyc < 400) begin
            for (int k = 0; k < 2; k++) begin
                if (!done[k]) begin
                    if (rsp_valid[k] === 1'b1) begin
                        done[k] = 1'b1; lat[k] = tick; rcnt[k] = 1;
                        got_d[k] = rsp_data[k]; got_to[k] = rsp_timeout[k];
                        req_valid[k] = 1'b0;
                    end else begin
                        if (req_ready[k] !== 1'b0) busy_rdy[k]++;
                        if (bus_addr[k] !== addr || bus_dout[k] !== data) addr_bad[k]++;
                    end
                end else if (rsp_valid[k] !== 1'b0) begin
                    rcnt[k]++;
                end
                if (rd[k] === 1'b0 && wr[k] === 1'b0) both_low[k]++;
            end
            if (done[0] && done[1]) begin
                post++;
                if (post >= 3) break;
            end
            CLK_EN = 1'($urandom_range(0, 1));
            if (CLK_EN) begin
                for (int k = 0; k < 2; k++) begin
                    if (!done[k]) begin
                        if (sltsl[k] === 1'b0) lo_s[k]++;
                        if (merq[k] === 1'b0) lo_m[k]++;
                        if (iorq[k] === 1'b0) lo_i[k]++;
                        if (rd[k] === 1'b0) lo_r[k]++;
                        if (wr[k] === 1'b0) lo_w[k]++;
                    end
                end
                WAIT_n = (tick + 1 < 64) ? ~wlo[tick + 1] : 1'b1;
                tick++;
            end else begin
                WAIT_n = 1'($urandom_range(0, 1));
            end
            cyc++;
            @(negedge CLK);
        end
        req_valid = 2'b00;

        for (int k = 0; k < 2; k++) begin
            model(k, tw, to);
            s = 2 + tw;
            exp_d = (to || w || busdir_n) ? 8'hFF : din;
            if (!done[k]) $display("FAIL rsp_seen dut%0d: no response within bound", k);
            else n_pass++;
            n_total++;
            if (lat[k] !== 3 + tw) $display("FAIL latency dut%0d: got %0d ticks want %0d", k, lat[k], 3 + tw);
            else n_pass++;
            n_total++;
            if (got_d[k] !== exp_d) $display("FAIL rsp_data dut%0d: got %h want %h", k, got_d[k], exp_d);
            else n_pass++;
            n_total++;
            if (got_to[k] !== to) $display("FAIL rsp_timeout dut%0d: got %b want %b", k, got_to[k], to);
            else n_pass++;
            n_total++;
            if (rcnt[k] !== 1) $display("FAIL rsp_pulse dut%0d: high %0d cycles want 1", k, rcnt[k]);
            else n_pass++;
            n_total++;
            if (busy_rdy[k] !== 0 || addr_bad[k] !== 0)
                $display("FAIL busy_bus dut%0d: ready_high=%0d addr_changes=%0d want 0/0", k, busy_rdy[k], addr_bad[k]);
            else n_pass++;
            n_total++;
            if (both_low[k] !== 0) $display("FAIL rd_wr_both_low dut%0d: got %0d want 0", k, both_low[k]);
            else n_pass++;
            n_total++;
            if (lo_s[k] !== (io ? 0 : s) || lo_m[k] !== (io ? 0 : s) || lo_i[k] !== (io ? s : 0))
                $display("FAIL select_ticks dut%0d: sltsl=%0d merq=%0d iorq=%0d want io=%b len %0d",
                         k, lo_s[k], lo_m[k], lo_i[k], io, s);
            else n_pass++;
            n_total++;
            if (lo_r[k] !== (w ? 0 : s) || lo_w[k] !== (w ? s : 0))
                $display("FAIL rdwr_ticks dut%0d: rd=%0d wr=%0d want wr=%b len %0d", k, lo_r[k], lo_w[k], w, s);
            else n_pass++;
            n_total++;
            if (req_ready[k] !== 1'b1) $display("FAIL ready_after dut%0d: got %b want 1", k, req_ready[k]);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic clear_waits();
        for (int i = 0; i < 64; i++) wlo[i] = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            if ({sltsl[k], merq[k], iorq[k], rd[k], wr[k]} !== 5'b11111)
                $display("FAIL reset_strobes dut%0d: got %b want 11111", k, {sltsl[k], merq[k], iorq[k], rd[k], wr[k]});
            else n_pass++;
            n_total++;
            if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_timeout[k] !== 1'b0)
                $display("FAIL reset_ctrl dut%0d: ready=%b valid=%b timeout=%b want 1/0/0",
                         k, req_ready[k], rsp_valid[k], rsp_timeout[k]);
            else n_pass++;
            n_total++;
            if (rsp_data[k] !== 8'hFF || bus_addr[k] !== 16'h0000 || bus_dout[k] !== 8'h00)
                $display("FAIL reset_data dut%0d: rsp=%h addr=%h dout=%h want FF/0000/00",
                         k, rsp_data[k], bus_addr[k], bus_dout[k]);
            else n_pass++;
            n_total++;
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_mem_read();
        clear_waits();
        run_txn(1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_io_write();
        clear_waits();
        run_txn(1'b1, 1'b1, 16'h0098, 8'h3C, 8'h55, 1'b0, 1'b0);
    endtask

    task automatic test_wait_read();
        clear_waits();
        for (int i = 2; i < 7; i++) wlo[i] = 1'b1;
        run_txn(1'b0, 1'b0, 16'h8123, 8'h00, 8'h6E, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 64; i++) wlo[i] = 1'b1;
        run_txn(1'b0, 1'b0, 16'h6000, 8'h00, 8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_empty_slot();
        clear_waits();
        run_txn(1'b0, 1'b0, 16'hBFFF, 8'h00, 8'h12, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit w, io, bd;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 64; i++) wlo[i] = 1'b1;
            end else begin
                for (int i = 0; i < 64; i++) wlo[i] = ($urandom_range(0, 2) == 0);
            end
            w  = 1'($urandom_range(0, 1));
            io = 1'($urandom_range(0, 1));
            bd = ($urandom_range(0, 3) == 0);
            run_txn(w, io, 16'($urandom), 8'($urandom), 8'($urandom), bd, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        clear_waits();
        wlo[2] = 1'b1;
        run_txn(1'b0, 1'b0, 16'h4010, 8'h77, 8'hC3, 1'b0, 1'b1);
        clear_waits();
        run_txn(1'b1, 1'b1, 16'h00A0, 8'h9D, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge CLK);
        REQ_WR = 1'b0; REQ_IO = 1'b0; REQ_ADDR = 16'h4444; REQ_DATA = 8'h00;
        BUS_DIN = 8'h3E; BUS_BUSDIR_n = 1'b0; WAIT_n = 1'b1;
        req_valid = 2'b11; CLK_EN = 1'b0;
        @(negedge CLK);
        req_valid = 2'b00; CLK_EN = 1'b1;
        @(negedge CLK);
        CLK_EN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rd[k] !== 1'b0 || merq[k] !== 1'b0 || sltsl[k] !== 1'b0)
                $display("FAIL t2_strobes dut%0d: rd=%b merq=%b sltsl=%b want 0/0/0", k, rd[k], merq[k], sltsl[k]);
            else n_pass++;
            n_total++;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if ({sltsl[k], merq[k], iorq[k], rd[k], wr[k]} !== 5'b11111 || req_ready[k] !== 1'b1)
                $display("FAIL midreset_state dut%0d: strobes=%b ready=%b want 11111/1",
                         k, {sltsl[k], merq[k], iorq[k], rd[k], wr[k]}, req_ready[k]);
            else n_pass++;
            n_total++;
            if (rsp_data[k] !== 8'hFF) $display("FAIL midreset_rsp_data dut%0d: got %h want FF", k, rsp_data[k]);
            else n_pass++;
            n_total++;
        end
        stray = 0;
        CLK_EN = 1'b1;
        repeat (30) begin
            @(negedge CLK);
            if (rsp_valid !== 2'b00) stray++;
        end
        CLK_EN = 1'b0;
        if (stray !== 0) $display("FAIL midreset_no_rsp: got %0d response cycles want 0", stray);
        else n_pass++;
        n_total++;
    endtask

    initial begin
        RESET = 1'b1; CLK_EN = 1'b0; WAIT_n = 1'b1; BUS_BUSDIR_n = 1'b1;
        REQ_WR = 1'b0; REQ_IO = 1'b0; REQ_ADDR = 16'h0; REQ_DATA = 8'h0;
        BUS_DIN = 8'h0; req_valid = 2'b00;
        clear_waits();

        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_read();
        test_timeout();
        test_empty_slot();
        test_back_to_back();
        test_random();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
